pwm_key_ctrl: RTL

Converts debounced key-press pulses from three key filters (UP, DOWN, MODE) into PWM configuration updates. It arbitrates simultaneous presses, tracks the edit mode, and applies saturating step arithmetic to the duty and divider values. Each new setting is pushed to the PWM generator over a valid/ready handshake. It sits between the key filter instances and the PWM/FM datapath.

---
 rtl/pwm_key_ctrl_if.sv | 25 ++
 rtl/pwm_key_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pwm_key_ctrl_if.sv
// Key pulses in, PWM configuration handshake out, plus the current edit mode.
// master = key controller, slave = key filters / PWM generator side.
interface pwm_key_ctrl_if #(
    parameter int DUTY_W = 8,
    parameter int DIV_W  = 16
);
    logic              key_up;
    logic              key_down;
    logic              key_mode;
    logic [DUTY_W-1:0] cfg_duty;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        mode;

    modport master (
        input  key_up, key_down, key_mode, cfg_ready,
        output cfg_duty, cfg_div, cfg_valid, mode
    );

    modport slave (
        output key_up, key_down, key_mode, cfg_ready,
        input  cfg_duty, cfg_div, cfg_valid, mode
    );
endinterface

// File: rtl/pwm_key_ctrl.sv
// Purpose: turns key pulses into saturating duty/divider updates for the PWM (KEY_ACCEL_EN adds 4x step on key streaks).
// Latency: 2 edges from pulse sample to cfg_valid; each queued request adds 2 edges plus the handshake wait.
// Backpressure: cfg_valid/cfg outputs held until cfg_ready; presses are latched as pending bits meanwhile (repeats merge).
module pwm_key_ctrl #(
    parameter int DUTY_W    = 8,
    parameter int DIV_W     = 16,
    parameter int DUTY_STEP = 8,
    parameter int DIV_STEP  = 256,
    parameter int DUTY_INIT = 128,
    parameter int DIV_INIT  = 1000,
    parameter int DIV_MIN   = 16,
    parameter int ACCEL_WIN = 3_000_000,
    parameter int ACCEL_CNT = 4
) (
    input logic               clk,
    input logic               rst_n,
    pwm_key_ctrl_if.master    bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_PUSH = 2'd2} state_t;
    typedef enum logic [1:0] {REQ_MODE = 2'd0, REQ_UP = 2'd1, REQ_DOWN = 2'd2} req_t;
    typedef enum logic [1:0] {MODE_DUTY = 2'b00, MODE_FREQ = 2'b01, MODE_LOCK = 2'b10} mode_t;

    state_t            state_q, state_nxt;
    req_t              req_q, req_nxt;
    mode_t             mode_q, mode_nxt;
    logic [2:0]        pend_q, pend_clr;   // {mode, up, down}
    logic [DUTY_W-1:0] duty_q, duty_nxt, duty_up, duty_dn, duty_cand;
    logic [DIV_W-1:0]  div_q, div_nxt, div_up, div_dn, div_cand;
    logic              valid_q, valid_nxt;
    logic [DUTY_W:0]   duty_step, duty_sum, duty_dif;
    logic [DIV_W:0]    div_step, div_sum, div_dif;

`ifdef KEY_ACCEL_EN
    localparam int SW = $clog2(ACCEL_CNT + 1);
    logic [23:0]   win_cnt;
    logic [SW-1:0] streak, streak_new;
    logic          last_vld, last_up, same_key, boost;

    always_comb begin
        same_key   = last_vld && (last_up == (req_q == REQ_UP)) && (win_cnt < 24'(ACCEL_WIN));
        streak_new = '0;
        if (same_key)
            streak_new = (streak >= SW'(ACCEL_CNT)) ? streak : streak + SW'(1);
        boost      = (streak_new >= SW'(ACCEL_CNT));
        duty_step  = boost ? (DUTY_W+1)'(4 * DUTY_STEP) : (DUTY_W+1)'(DUTY_STEP);
        div_step   = boost ? (DIV_W+1)'(4 * DIV_STEP) : (DIV_W+1)'(DIV_STEP);
    end

    // Window restarts on each served UP/DOWN; MODE breaks any streak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            streak   <= '0;
            last_vld <= 1'b0;
            last_up  <= 1'b0;
        end else begin
            win_cnt <= (&win_cnt) ? win_cnt : win_cnt + 24'd1;
            if (state_q == S_CALC) begin
                if (req_q == REQ_MODE) begin
                    streak   <= '0;
                    last_vld <= 1'b0;
                end else begin
                    streak   <= streak_new;
                    last_vld <= 1'b1;
                    last_up  <= (req_q == REQ_UP);
                    win_cnt  <= '0;
                end
            end
        end
    end
`else
    assign duty_step = (DUTY_W+1)'(DUTY_STEP);
    assign div_step  = (DIV_W+1)'(DIV_STEP);
`endif

    // One extra bit catches carry/borrow so results clamp instead of wrapping.
    always_comb begin
        duty_sum  = {1'b0, duty_q} + duty_step;
        duty_dif  = {1'b0, duty_q} - duty_step;
        duty_up   = duty_sum[DUTY_W] ? {DUTY_W{1'b1}} : duty_sum[DUTY_W-1:0];
        duty_dn   = duty_dif[DUTY_W] ? '0 : duty_dif[DUTY_W-1:0];
        div_sum   = {1'b0, div_q} + div_step;
        div_dif   = {1'b0, div_q} - div_step;
        div_up    = (div_dif[DIV_W] || (div_dif < (DIV_W+1)'(DIV_MIN))) ? DIV_W'(DIV_MIN)
                                                                         : div_dif[DIV_W-1:0];
        div_dn    = div_sum[DIV_W] ? {DIV_W{1'b1}} : div_sum[DIV_W-1:0];
        duty_cand = (req_q == REQ_UP) ? duty_up : duty_dn;
        div_cand  = (req_q == REQ_UP) ? div_up : div_dn;
    end

    always_comb begin
        state_nxt = state_q;
        req_nxt   = req_q;
        mode_nxt  = mode_q;
        pend_clr  = 3'b000;
        duty_nxt  = duty_q;
        div_nxt   = div_q;
        valid_nxt = valid_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q[2]) begin
                    pend_clr = 3'b100; req_nxt = REQ_MODE; state_nxt = S_CALC;
                end else if (pend_q[1]) begin
                    pend_clr = 3'b010; req_nxt = REQ_UP;   state_nxt = S_CALC;
                end else if (pend_q[0]) begin
                    pend_clr = 3'b001; req_nxt = REQ_DOWN; state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                state_nxt = S_IDLE;
                if (req_q == REQ_MODE) begin
                    case (mode_q)
                        MODE_DUTY: mode_nxt = MODE_FREQ;
                        MODE_FREQ: mode_nxt = MODE_LOCK;
                        default:   mode_nxt = MODE_DUTY;
                    endcase
                end else if (mode_q == MODE_DUTY) begin
                    if (duty_cand != duty_q) begin
                        duty_nxt = duty_cand; valid_nxt = 1'b1; state_nxt = S_PUSH;
                    end
                end else if (mode_q == MODE_FREQ) begin
                    if (div_cand != div_q) begin
                        div_nxt = div_cand; valid_nxt = 1'b1; state_nxt = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                if (bus.cfg_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= REQ_MODE;
            mode_q  <= MODE_DUTY;
            pend_q  <= 3'b000;
            duty_q  <= DUTY_W'(DUTY_INIT);
            div_q   <= DIV_W'(DIV_INIT);
            valid_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            req_q   <= req_nxt;
            mode_q  <= mode_nxt;
            // A new pulse wins over the clear of the same bit.
            pend_q  <= (pend_q & ~pend_clr) | {bus.key_mode, bus.key_up, bus.key_down};
            duty_q  <= duty_nxt;
            div_q   <= div_nxt;
            valid_q <= valid_nxt;
        end
    end

    assign bus.cfg_duty  = duty_q;
    assign bus.cfg_div   = div_q;
    assign bus.cfg_valid = valid_q;
    assign bus.mode      = mode_q;
endmodule
